// File: rtl/syscall_pkg.sv
// Shared constants and types for the syscall console: service codes, FSM states,
// the decimal power table and a byte-lane picker for string words.
package syscall_pkg;

   localparam logic [31:0] SYS_PRINT_INT  = 32'd1;
   localparam logic [31:0] SYS_PRINT_STR  = 32'd4;
   localparam logic [31:0] SYS_EXIT       = 32'd10;
   localparam logic [31:0] SYS_PRINT_CHAR = 32'd11;

   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;

   localparam logic [31:0] POW10 [0:9] = '{
      32'd1000000000, 32'd100000000, 32'd10000000, 32'd1000000, 32'd100000,
      32'd10000,      32'd1000,      32'd100,      32'd10,       32'd1
   };

   typedef enum logic [2:0] {
      IDLE, INT_SIGN, INT_DIGIT, STR_FETCH, STR_EMIT, CHR_EMIT, HALTED
   } state_e;

   typedef enum logic [1:0] {
      E_IDLE, E_SUB, E_OUT
   } eng_state_e;

   // Byte 0 of a word is the lowest address; big-endian puts it in bits [31:24].
   function automatic logic [7:0] pick_byte(input logic [31:0] word,
                                            input logic [1:0]  off,
                                            input logic        big_endian);
      logic [1:0] lane;
      logic [7:0] b;
      lane = big_endian ? ~off : off;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/syscall_console_if.sv
// Bundle of the request, data-memory and console signals of the syscall console.
interface syscall_console_if;

   // Every channel is valid/ready: a transfer happens on a rising edge with both high;
   // the sender holds valid and payload stable until that edge, ready may change freely.
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_code;
   logic [31:0] req_arg;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic        char_valid;
   logic [7:0]  char_data;
   logic        char_ready;
   logic        busy;
   logic        halt;
   logic        err;

   modport master (
      output req_valid, req_code, req_arg, mem_ack, mem_rdata, char_ready,
      input  req_ready, mem_req, mem_addr, char_valid, char_data, busy, halt, err
   );

   modport slave (
      input  req_valid, req_code, req_arg, mem_ack, mem_rdata, char_ready,
      output req_ready, mem_req, mem_addr, char_valid, char_data, busy, halt, err
   );

endinterface

// File: rtl/syscall_int2dec.sv
// Decimal digit engine: takes a signed 32-bit value, produces its magnitude digits
// most-significant first by one subtraction per cycle, skipping leading zeros.
module syscall_int2dec
   import syscall_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_i,
   input  logic [31:0] value_i,
   input  logic        digit_ready_i,
   output logic        digit_valid_o,
   output logic [7:0]  digit_o,
   output logic        done_o
);

   eng_state_e  state_q, state_d;
   logic [31:0] rem_q, rem_d;
   logic [3:0]  idx_q, idx_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        lead_q, lead_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= E_IDLE;
         rem_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         lead_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         lead_q  <= lead_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      rem_d         = rem_q;
      idx_d         = idx_q;
      cnt_d         = cnt_q;
      lead_d        = lead_q;
      digit_valid_o = 1'b0;
      done_o        = 1'b0;
      case (state_q)
         E_IDLE: begin
            if (start_i) begin
               // Two's-complement negate also maps 0x80000000 to 2147483648 unsigned.
               rem_d   = value_i[31] ? (~value_i + 32'd1) : value_i;
               idx_d   = '0;
               cnt_d   = '0;
               lead_d  = 1'b1;
               state_d = E_SUB;
            end
         end
         E_SUB: begin
            if (rem_q >= POW10[idx_q]) begin
               rem_d = rem_q - POW10[idx_q];
               cnt_d = cnt_q + 4'd1;
            end else if (lead_q && (cnt_q == 4'd0) && (idx_q != 4'd9)) begin
               idx_d = idx_q + 4'd1;
            end else begin
               state_d = E_OUT;
            end
         end
         E_OUT: begin
            digit_valid_o = 1'b1;
            if (digit_ready_i) begin
               lead_d = 1'b0;
               cnt_d  = '0;
               if (idx_q == 4'd9) begin
                  done_o  = 1'b1;
                  state_d = E_IDLE;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = E_SUB;
               end
            end
         end
         default: state_d = E_IDLE;
      endcase
   end

   assign digit_o = ASCII_ZERO + {4'd0, cnt_q};

endmodule

// File: rtl/syscall_console.sv
// Syscall service stage: accepts one $v0/$a0 request at a time and turns it into
// console bytes (int, string, char), an exit halt, or an error pulse.
module syscall_console
   import syscall_pkg::*;
#(
   parameter int unsigned MAX_STR_LEN = 1024,
   parameter bit          BIG_ENDIAN  = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   syscall_console_if.slave bus,
   output state_e           state_o
);

   localparam int             SLW      = $clog2(MAX_STR_LEN + 1);
   localparam logic [SLW-1:0] STR_LAST = SLW'(MAX_STR_LEN - 1);

   state_e         state_q, state_d;
   logic [31:0]    ptr_q, ptr_d;
   logic [31:0]    word_q, word_d;
   logic [SLW-1:0] slen_q, slen_d;
   logic           err_q, err_d;
   logic           live_q;

   logic       eng_start, eng_ready, eng_valid, eng_done;
   logic [7:0] eng_digit;
   logic [7:0] str_byte;
   logic       accept;

   syscall_int2dec u_int2dec (
      .clk           (clk),
      .rst_n         (rst_n),
      .start_i       (eng_start),
      .value_i       (bus.req_arg),
      .digit_ready_i (eng_ready),
      .digit_valid_o (eng_valid),
      .digit_o       (eng_digit),
      .done_o        (eng_done)
   );

   // live_q keeps req_ready low while reset is held, so every output reads 0 in reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         word_q  <= '0;
         slen_q  <= '0;
         err_q   <= 1'b0;
         live_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         word_q  <= word_d;
         slen_q  <= slen_d;
         err_q   <= err_d;
         live_q  <= 1'b1;
      end
   end

   assign str_byte = pick_byte(word_q, ptr_q[1:0], BIG_ENDIAN);
   assign accept   = bus.req_valid && bus.req_ready;

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      word_d         = word_q;
      slen_d         = slen_q;
      err_d          = 1'b0;
      eng_start      = 1'b0;
      eng_ready      = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_addr   = '0;
      bus.char_valid = 1'b0;
      bus.char_data  = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               case (bus.req_code)
                  SYS_PRINT_INT: begin
                     eng_start = 1'b1;
                     state_d   = bus.req_arg[31] ? INT_SIGN : INT_DIGIT;
                  end
                  SYS_PRINT_STR: begin
                     ptr_d   = bus.req_arg;
                     slen_d  = '0;
                     state_d = STR_FETCH;
                  end
                  SYS_PRINT_CHAR: begin
                     word_d  = bus.req_arg;
                     state_d = CHR_EMIT;
                  end
                  SYS_EXIT: state_d = HALTED;
                  default:  err_d   = 1'b1;
               endcase
            end
         end
         INT_SIGN: begin
            bus.char_valid = 1'b1;
            bus.char_data  = ASCII_MINUS;
            if (bus.char_ready) state_d = INT_DIGIT;
         end
         INT_DIGIT: begin
            bus.char_valid = eng_valid;
            bus.char_data  = eng_digit;
            eng_ready      = bus.char_ready;
            if (eng_done) state_d = IDLE;
         end
         STR_FETCH: begin
            bus.mem_req  = 1'b1;
            bus.mem_addr = {ptr_q[31:2], 2'b00};
            if (bus.mem_ack) begin
               word_d  = bus.mem_rdata;
               state_d = STR_EMIT;
            end
         end
         STR_EMIT: begin
            if (str_byte == 8'h00) begin
               state_d = IDLE;
            end else begin
               bus.char_valid = 1'b1;
               bus.char_data  = str_byte;
               if (bus.char_ready) begin
                  ptr_d  = ptr_q + 32'd1;
                  slen_d = slen_q + SLW'(1);
                  // The guard wins over a refetch: the string is abandoned here.
                  if (slen_q == STR_LAST) begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end else if (ptr_q[1:0] == 2'd3) begin
                     state_d = STR_FETCH;
                  end
               end
            end
         end
         CHR_EMIT: begin
            bus.char_valid = 1'b1;
            bus.char_data  = word_q[7:0];
            if (bus.char_ready) state_d = IDLE;
         end
         HALTED:  state_d = HALTED;
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready = live_q && (state_q == IDLE);
   assign bus.busy      = (state_q != IDLE) && (state_q != HALTED);
   assign bus.halt      = (state_q == HALTED);
   assign bus.err       = err_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_syscall_console.sv
// Self-checking bench for syscall_console: randomized requests against a byte-level
// memory model and a printf-based reference for integers.
module tb_syscall_console;
   import syscall_pkg::*;

   logic   clk;
   logic   rst_n;
   state_e state_dbg;
   int     checks = 0;
   int     errors = 0;
   int     cyc = 0;
   int     mem_delay = 0;
   int     rdy_mode = 0;
   int     err_seen = 0;
   logic [7:0]  fill_byte = 8'h00;
   logic [7:0]  bmem [logic [31:0]];
   logic [31:0] rd_q [$];
   logic [7:0]  exp_q [$];
   logic [7:0]  got_q [$];

   syscall_console_if bus ();

   syscall_console #(.MAX_STR_LEN(1024), .BIG_ENDIAN(1'b1)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .state_o (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #900000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1);
   end

   // ---------------- memory model (byte addressed, big-endian words) ----------------
   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      if (bmem.exists(a)) return bmem[a];
      return fill_byte;
   endfunction

   initial begin
      int          wcnt;
      logic [31:0] held;
      wcnt = 0;
      held = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end else if (bus.mem_req) begin
            checks++;
            if (bus.mem_addr[1:0] != 2'b00 || (wcnt > 0 && bus.mem_addr != held)) begin
               errors++;
               $display("FAIL mem_addr_stable got=%h held=%h", bus.mem_addr, held);
            end
            held = bus.mem_addr;
            if (wcnt >= mem_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = {mem_byte(held), mem_byte(held + 32'd1),
                                mem_byte(held + 32'd2), mem_byte(held + 32'd3)};
               rd_q.push_back(held);
            end else begin
               wcnt++;
            end
         end
      end
   end

   // ---------------- console sink + err monitor ----------------
   initial begin
      bit         pend;
      logic [7:0] pend_data;
      pend = 1'b0;
      pend_data = '0;
      bus.char_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rdy_mode)
            0:       bus.char_ready = 1'b1;
            1:       bus.char_ready = ~bus.char_ready;
            default: bus.char_ready = 1'($urandom_range(0, 1));
         endcase
         if (rst_n && pend) begin
            checks++;
            if (bus.char_valid !== 1'b1 || bus.char_data !== pend_data) begin
               errors++;
               $display("FAIL char_hold got=%b/%h need=1/%h", bus.char_valid, bus.char_data, pend_data);
            end
         end
         if (rst_n && bus.char_valid && bus.char_ready) got_q.push_back(bus.char_data);
         pend      = rst_n && bus.char_valid && !bus.char_ready;
         pend_data = bus.char_data;
         if (rst_n && bus.err === 1'b1) err_seen++;
      end
   end

   // ---------------- scoreboard helpers ----------------
   function automatic string q2s(input logic [7:0] q[$]);
      string s = "";
      for (int i = 0; i < q.size() && i < 40; i++) s = {s, $sformatf("%02h", q[i])};
      if (q.size() > 40) s = {s, "..."};
      return s;
   endfunction

   function automatic bit same_q();
      if (got_q.size() != exp_q.size()) return 1'b0;
      foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic void push_str(input string s);
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endfunction

   task automatic clear_sb();
      exp_q.delete();
      got_q.delete();
      rd_q.delete();
      err_seen = 0;
   endtask

   // ---------------- drivers ----------------
   task automatic send_req(input logic [31:0] code, input logic [31:0] arg,
                           input int budget, output bit ok);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_code  = code;
      bus.req_arg   = arg;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.req_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (ok) @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic run_op(input logic [31:0] code, input logic [31:0] arg,
                         input int budget, output bit ok);
      bit acc;
      bit idle;
      send_req(code, arg, 20, acc);
      idle = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.busy === 1'b0) begin
            idle = 1'b1;
            break;
         end
         @(negedge clk);
      end
      ok = acc && idle;
      repeat (2) @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_code  = '0;
      bus.req_arg   = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.req_ready, bus.mem_req, bus.char_valid, bus.busy, bus.halt, bus.err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_outputs got=%b need=000000",
                  {bus.req_ready, bus.mem_req, bus.char_valid, bus.busy, bus.halt, bus.err});
      end
      checks++;
      if (state_dbg !== IDLE) begin
         errors++;
         $display("FAIL reset_state got=%s need=IDLE", state_dbg.name());
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_ready got=%b/%b need=1/0", bus.req_ready, bus.busy);
      end
   endtask

   task automatic test_print_int();
      logic [31:0] args[$];
      bit ok;
      args = '{32'h8000_0000, 32'd0, 32'd1000, 32'd7, 32'hFFFF_FFFF, 32'd9, 32'd10};
      repeat (8) args.push_back($urandom);
      foreach (args[i]) begin
         clear_sb();
         rdy_mode = (i == 3) ? 1 : ((i < 3) ? 0 : int'($urandom_range(0, 2)));
         push_str($sformatf("%0d", $signed(args[i])));
         run_op(SYS_PRINT_INT, args[i], 600, ok);
         checks++;
         if (!ok || !same_q()) begin
            errors++;
            $display("FAIL int_stream arg=%h ok=%b got=%s need=%s", args[i], ok, q2s(got_q), q2s(exp_q));
         end
         checks++;
         if (err_seen != 0 || rd_q.size() != 0) begin
            errors++;
            $display("FAIL int_side_effects err=%0d reads=%0d need=0/0", err_seen, rd_q.size());
         end
      end
   endtask

   task automatic put_str(input logic [31:0] a, input string s);
      for (int i = 0; i < s.len(); i++) bmem[a + 32'(i)] = s[i];
   endtask

   task automatic test_print_str();
      bit ok;
      int d;
      bmem.delete();
      fill_byte = 8'h00;
      put_str(32'h1000, "ABCDEF");
      bmem[32'h1006] = 8'h00;
      bmem[32'h1007] = "x";
      for (int k = 0; k < 2; k++) begin
         clear_sb();
         mem_delay = (k == 0) ? 0 : 3;
         rdy_mode = 0;
         push_str("CDEF");
         run_op(SYS_PRINT_STR, 32'h1002, 200, ok);
         checks++;
         if (!ok || !same_q()) begin
            errors++;
            $display("FAIL str_fixed delay=%0d got=%s need=%s", mem_delay, q2s(got_q), q2s(exp_q));
         end
         checks++;
         if (rd_q.size() != 2 || rd_q[0] !== 32'h1000 || rd_q[1] !== 32'h1004) begin
            errors++;
            $display("FAIL str_reads n=%0d need=2 at 1000,1004", rd_q.size());
         end
      end
      repeat (6) begin
         logic [31:0] p;
         int len;
         int nrd;
         clear_sb();
         bmem.delete();
         p = 32'h3000 + 32'($urandom_range(0, 255));
         len = $urandom_range(0, 11);
         for (int i = 0; i < len; i++) begin
            bmem[p + 32'(i)] = 8'($urandom_range(1, 255));
            exp_q.push_back(bmem[p + 32'(i)]);
         end
         bmem[p + 32'(len)] = 8'h00;
         mem_delay = $urandom_range(0, 3);
         rdy_mode = $urandom_range(0, 2);
         nrd = int'(((p + 32'(len)) >> 2) - (p >> 2)) + 1;
         run_op(SYS_PRINT_STR, p, 400, ok);
         checks++;
         if (!ok || !same_q() || rd_q.size() != nrd) begin
            errors++;
            $display("FAIL str_rand ptr=%h got=%s need=%s reads=%0d need=%0d",
                     p, q2s(got_q), q2s(exp_q), rd_q.size(), nrd);
         end
      end
      d = 0;
      mem_delay = d;
   endtask

   task automatic test_str_guard();
      bit ok;
      clear_sb();
      bmem.delete();
      fill_byte = "a";
      mem_delay = 0;
      rdy_mode = 0;
      repeat (1024) exp_q.push_back("a");
      run_op(SYS_PRINT_STR, 32'h8000, 4000, ok);
      checks++;
      if (!ok || !same_q() || rd_q.size() != 256) begin
         errors++;
         $display("FAIL str_guard n=%0d need=1024 reads=%0d need=256", got_q.size(), rd_q.size());
      end
      checks++;
      if (err_seen != 1 || state_dbg !== IDLE) begin
         errors++;
         $display("FAIL str_guard_err pulses=%0d state=%s need=1/IDLE", err_seen, state_dbg.name());
      end
      clear_sb();
      fill_byte = 8'h00;
      bmem[32'h5000] = 8'h00;
      run_op(SYS_PRINT_STR, 32'h5000, 100, ok);
      checks++;
      if (!ok || got_q.size() != 0 || rd_q.size() != 1 || err_seen != 0) begin
         errors++;
         $display("FAIL str_empty chars=%0d reads=%0d err=%0d need=0/1/0", got_q.size(), rd_q.size(), err_seen);
      end
   endtask

   task automatic test_bad_code();
      logic [31:0] codes[$];
      bit ok;
      codes = '{32'd5, 32'd0};
      codes.push_back(32'd12 + 32'($urandom_range(0, 1000)));
      foreach (codes[i]) begin
         clear_sb();
         send_req(codes[i], $urandom, 20, ok);
         checks++;
         if (!ok || bus.err !== 1'b1 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bad_code code=%0d acc=%b err=%b ready=%b need=1/1/1",
                     codes[i], ok, bus.err, bus.req_ready);
         end
         repeat (3) @(negedge clk);
         checks++;
         if (err_seen != 1 || got_q.size() != 0) begin
            errors++;
            $display("FAIL bad_code_pulse pulses=%0d chars=%0d need=1/0", err_seen, got_q.size());
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] args[3];
      int acc[3];
      int k;
      clear_sb();
      rdy_mode = 0;
      args = '{32'h48, 32'h100, 32'h69};
      exp_q = '{8'h48, 8'h00, 8'h69};
      acc = '{0, 0, 0};
      k = 0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_code  = SYS_PRINT_CHAR;
      bus.req_arg   = args[0];
      for (int g = 0; g < 40 && k < 3; g++) begin
         if (bus.req_ready === 1'b1) begin
            acc[k] = cyc;
            k++;
            @(negedge clk);
            if (k < 3) bus.req_arg = args[k];
            else bus.req_valid = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      bus.req_valid = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (k != 3 || !same_q()) begin
         errors++;
         $display("FAIL b2b_stream accepted=%0d got=%s need=%s", k, q2s(got_q), q2s(exp_q));
      end
      checks++;
      if (acc[1] - acc[0] != 2 || acc[2] - acc[1] != 2) begin
         errors++;
         $display("FAIL b2b_gap got=%0d,%0d need=2,2", acc[1] - acc[0], acc[2] - acc[1]);
      end
   endtask

   task automatic test_exit();
      bit ok;
      clear_sb();
      send_req(SYS_EXIT, 32'd0, 20, ok);
      checks++;
      if (!ok || bus.halt !== 1'b1 || bus.busy !== 1'b0 || bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL exit_halt acc=%b halt=%b busy=%b ready=%b need=1/1/0/0",
                  ok, bus.halt, bus.busy, bus.req_ready);
      end
      send_req(SYS_PRINT_CHAR, 32'h41, 20, ok);
      checks++;
      if (ok || got_q.size() != 0 || rd_q.size() != 0 || bus.halt !== 1'b1) begin
         errors++;
         $display("FAIL exit_sticky acc=%b chars=%0d halt=%b need=0/0/1", ok, got_q.size(), bus.halt);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.halt !== 1'b0 || bus.req_ready !== 1'b0) begin
         errors++;
         $display("FAIL exit_reset halt=%b ready=%b need=0/0", bus.halt, bus.req_ready);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit acc;
      clear_sb();
      bmem.delete();
      fill_byte = "z";
      mem_delay = 2;
      rdy_mode = 1;
      send_req(SYS_PRINT_STR, 32'h9001, 20, acc);
      repeat (12) @(negedge clk);
      checks++;
      if (!acc || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL mid_busy acc=%b busy=%b need=1/1", acc, bus.busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.mem_req, bus.char_valid, bus.busy, bus.halt, bus.req_ready} !== 5'b0) begin
         errors++;
         $display("FAIL mid_reset got=%b need=00000",
                  {bus.mem_req, bus.char_valid, bus.busy, bus.halt, bus.req_ready});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_sb();
      mem_delay = 0;
      rdy_mode = 0;
      exp_q.push_back(8'h41);
      run_op(SYS_PRINT_CHAR, 32'h41, 50, ok);
      checks++;
      if (!ok || !same_q() || rd_q.size() != 0) begin
         errors++;
         $display("FAIL after_reset_char got=%s need=%s", q2s(got_q), q2s(exp_q));
      end
   endtask

   initial begin
      test_reset();
      test_print_int();
      test_print_str();
      test_str_guard();
      test_bad_code();
      test_back_to_back();
      test_exit();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
